instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Decoupling FIFO between instruction fetch (IF) and decode (ID) in the RV64 pipeline.
//  Buffers {pc, instr} pairs from fetch. Presents the oldest entry first-word-fall-through
//  to decode, which drives the instruction word into the immediate generator.
//  A branch/jump redirect flush discards all buffered entries.
// PARAMETERS
//  DEPTH    4   entries; power of two, >= 2
//  PC_W     64  PC width
//  INSTR_W  32  instruction width
// PORTS
//  i_clk        in   1                  clock
//  i_rst        in   1                  synchronous reset, active-high
//  i_flush      in   1                  redirect: discard all entries
//  i_if_valid   in   1                  fetch presents an entry
//  o_if_ready   out  1                  queue accepts an entry
//  i_if_instr   in   INSTR_W            fetched instruction
//  i_if_pc      in   PC_W               PC of fetched instruction
//  o_id_valid   out  1                  head entry valid
//  i_id_ready   in   1                  decode consumes head
//  o_id_instr   out  INSTR_W            head instruction (NOP when empty)
//  o_id_pc      out  PC_W               head PC (0 when empty)
//  o_count      out  $clog2(DEPTH+1)    occupancy
// BEHAVIOUR
//  - One clock, i_clk. Reset is synchronous and active-high on i_rst.
//    While i_rst is high: rd_ptr=wr_ptr=0, count=0, o_id_valid=0, o_if_ready=0,
//    o_id_instr=32'h0000_0013 (addi x0,x0,0), o_id_pc=0.
//  - First cycle after reset deasserts: o_if_ready=1, queue empty.
//  - push = i_if_valid & o_if_ready & ~i_flush.
//    pop  = o_id_valid & i_id_ready & ~i_flush.
//  - o_if_ready = (count != DEPTH).
//    o_if_ready must not depend combinationally on i_id_ready; a full queue blocks push
//    even when pop happens in the same cycle.
//  - o_id_valid = (count != 0).
//    o_id_instr/o_id_pc are driven from the storage slot at rd_ptr.
//    When empty, they are forced to the NOP/0 values. Fetch-to-decode latency is 1 cycle.
//  - push: write slot wr_ptr, wr_ptr+1.
//    pop: rd_ptr+1.
//    Pointers wrap modulo DEPTH (DEPTH-1 -> 0).
//  - count update:
//    push only: count+1.
//    pop only: count-1.
//    push and pop in the same cycle: count unchanged, head advances, new entry stored.
//  - Flush: in the cycle i_flush=1, push and pop are suppressed. Next cycle:
//    count=0, rd_ptr=wr_ptr=0, o_id_valid=0, o_if_ready=1.
//    i_flush takes priority over push and pop. i_rst takes priority over i_flush.
//  - Payload on i_if_* is sampled only on push. o_id_* stay stable while
//    o_id_valid=1 and i_id_ready=0.
//  - Reset or flush mid-stream loses all entries; no partial entries survive.
//  - Storage array needs no reset; only pointers and count are reset.
//  - count never exceeds DEPTH and never underflows.
//    Assertions flag push when full and pop when empty.
// TESTING
//  1 Reset: hold i_rst 3 cycles -> o_id_valid=0, o_if_ready=0, o_id_instr=0x00000013,
//    o_count=0. Release -> o_if_ready=1.
//  2 Fill: push pc=0x1000..0x100C with instr=0xA0..0xA3, i_id_ready=0 ->
//    o_count=4, o_if_ready=0, head pc=0x1000 and instr=0xA0 stable.
//  3 Drain with wrap: from full, i_id_ready=1 for 6 cycles while pushing 0x1010, 0x1014
//    -> order 0x1000..0x1014 emitted, pointers wrap, o_count ends at 0.
//  4 Simultaneous push/pop at count=2 -> o_count stays 2, head advances by one entry.
//  5 Flush at count=3 with i_if_valid=1 and i_id_ready=1 -> no pop, no push.
//    Next cycle o_count=0, o_id_valid=0, o_id_instr=0x00000013.
//  6 Reset mid-stream: at count=2, assert i_rst 1 cycle -> identical to the post-reset
//    state in test 1. A following push of pc=0x2000 appears at head 1 cycle later.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decode pop side, occupancy.
interface instr_fetch_queue_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               i_flush;
    logic               i_if_valid;
    logic               o_if_ready;
    logic [INSTR_W-1:0] i_if_instr;
    logic [PC_W-1:0]    i_if_pc;
    logic               o_id_valid;
    logic               i_id_ready;
    logic [INSTR_W-1:0] o_id_instr;
    logic [PC_W-1:0]    o_id_pc;
    logic [CNT_W-1:0]   o_count;

    modport slave (
        input  i_flush, i_if_valid, i_if_instr, i_if_pc, i_id_ready,
        output o_if_ready, o_id_valid, o_id_instr, o_id_pc, o_count
    );

    modport master (
        output i_flush, i_if_valid, i_if_instr, i_if_pc, i_id_ready,
        input  o_if_ready, o_id_valid, o_id_instr, o_id_pc, o_count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// IF->ID decoupling FIFO: first-word-fall-through head, flush on redirect, NOP when empty.
module instr_fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    instr_fetch_queue_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ready_q,  ready_d;
    logic             valid_q,  valid_d;
    logic             push;
    logic             pop;

    // Ready is a flop so it never sees i_id_ready; a full queue blocks push even on pop.
    assign push = bus.i_if_valid & ready_q & ~bus.i_flush;
    assign pop  = valid_q & bus.i_id_ready & ~bus.i_flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != CNT_W'(DEPTH));
        valid_d = (count_d != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem_q[wr_ptr_q] <= '{pc: bus.i_if_pc, instr: bus.i_if_instr};
        end
    end

    assign bus.o_if_ready = ready_q;
    assign bus.o_id_valid = valid_q;
    assign bus.o_id_instr = valid_q ? mem_q[rd_ptr_q].instr : NOP_INSTR;
    assign bus.o_id_pc    = valid_q ? mem_q[rd_ptr_q].pc    : '0;
    assign bus.o_count    = count_q;

    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(push && (count_q == CNT_W'(DEPTH))));
            assert (!(pop && (count_q == '0)));
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: reset, fill, wrap drain, push/pop, flush, mid-stream reset.
module tb_instr_fetch_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    instr_fetch_queue_if #(.DEPTH(4), .PC_W(64), .INSTR_W(32)) bus ();

    instr_fetch_queue #(.DEPTH(4), .PC_W(64), .INSTR_W(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                         input logic rdy, input logic fl);
        bus.i_if_valid = v;
        bus.i_if_pc    = pc;
        bus.i_if_instr = instr;
        bus.i_id_ready = rdy;
        bus.i_flush    = fl;
    endtask

    task automatic push_one(input logic [63:0] pc, input logic [31:0] instr);
        drive(1'b1, pc, instr, 1'b0, 1'b0);
        step();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".valid"}, 64'(bus.o_id_valid), 64'd0);
        check({tag, ".ready"}, 64'(bus.o_if_ready), 64'd0);
        check({tag, ".instr"}, 64'(bus.o_id_instr), 64'h13);
        check({tag, ".pc"},    bus.o_id_pc,         64'h0);
        check({tag, ".count"}, 64'(bus.o_count),    64'd0);
    endtask

    logic [63:0] exp_pc    [6];
    logic [31:0] exp_instr [6];
    logic [2:0]  exp_cnt   [6];
    logic        drv_v     [6];
    logic [63:0] drv_pc    [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        // 1: reset held three cycles, then release
        repeat (3) step();
        check_idle_reset("rst");
        rst = 1'b0;
        step();
        check("rel.ready", 64'(bus.o_if_ready), 64'd1);
        check("rel.valid", 64'(bus.o_id_valid), 64'd0);

        // 2: fill with decode stalled
        for (int i = 0; i < 4; i++) begin
            push_one(64'h1000 + 64'(4 * i), 32'hA0 + 32'(i));
            check($sformatf("fill.count%0d", i), 64'(bus.o_count), 64'(i + 1));
        end
        check("fill.ready", 64'(bus.o_if_ready), 64'd0);
        check("fill.pc",    bus.o_id_pc,         64'h1000);
        check("fill.instr", 64'(bus.o_id_instr), 64'hA0);
        drive(1'b1, 64'h1010, 32'hA4, 1'b0, 1'b0);
        step();
        check("stall.count", 64'(bus.o_count),    64'd4);
        check("stall.pc",    bus.o_id_pc,         64'h1000);
        check("stall.instr", 64'(bus.o_id_instr), 64'hA0);

        // 3: drain six while pushing 0x1010 (blocked first cycle) and 0x1014
        exp_pc    = '{64'h1000, 64'h1004, 64'h1008, 64'h100C, 64'h1010, 64'h1014};
        exp_instr = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        exp_cnt   = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        drv_v     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drv_pc    = '{64'h1010, 64'h1010, 64'h1014, 64'h0, 64'h0, 64'h0};
        for (int k = 0; k < 6; k++) begin
            drive(drv_v[k], drv_pc[k], (drv_pc[k] == 64'h1014) ? 32'hA5 : 32'hA4, 1'b1, 1'b0);
            if (k == 0) check("drain.full_ready", 64'(bus.o_if_ready), 64'd0);
            check($sformatf("drain.pc%0d", k),    bus.o_id_pc,         exp_pc[k]);
            check($sformatf("drain.instr%0d", k), 64'(bus.o_id_instr), 64'(exp_instr[k]));
            step();
            check($sformatf("drain.count%0d", k), 64'(bus.o_count), 64'(exp_cnt[k]));
        end
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("drain.valid", 64'(bus.o_id_valid), 64'd0);
        check("drain.nop",   64'(bus.o_id_instr), 64'h13);
        check("drain.pc0",   bus.o_id_pc,         64'h0);

        // 4: simultaneous push/pop at count 2
        push_one(64'h3000, 32'hB0);
        push_one(64'h3004, 32'hB1);
        drive(1'b1, 64'h3008, 32'hB2, 1'b1, 1'b0);
        step();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("pp.count", 64'(bus.o_count),    64'd2);
        check("pp.pc",    bus.o_id_pc,         64'h3004);
        check("pp.instr", 64'(bus.o_id_instr), 64'hB1);

        // 5: flush at count 3 with push and pop requested
        push_one(64'h300C, 32'hB3);
        check("fl.pre_count", 64'(bus.o_count), 64'd3);
        drive(1'b1, 64'h3010, 32'hB4, 1'b1, 1'b1);
        step();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        check("fl.count", 64'(bus.o_count),    64'd0);
        check("fl.valid", 64'(bus.o_id_valid), 64'd0);
        check("fl.nop",   64'(bus.o_id_instr), 64'h13);
        check("fl.ready", 64'(bus.o_if_ready), 64'd1);

        // 6: reset mid-stream at count 2
        push_one(64'h4000, 32'hC0);
        push_one(64'h4004, 32'hC1);
        check("mr.pre_count", 64'(bus.o_count), 64'd2);
        rst = 1'b1;
        step();
        check_idle_reset("mr");
        rst = 1'b0;
        step();
        check("mr.ready", 64'(bus.o_if_ready), 64'd1);
        push_one(64'h2000, 32'hC2);
        check("mr.valid", 64'(bus.o_id_valid), 64'd1);
        check("mr.pc",    bus.o_id_pc,         64'h2000);
        check("mr.instr", 64'(bus.o_id_instr), 64'hC2);
        check("mr.count", 64'(bus.o_count),    64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
